adder_pipe_sched: RTL

//  Round-robin scheduler sharing one 4-stage adder_pipe_64bit (65-bit result) among NREQ requesters.

---
 rtl/adder_pipe_pkg.sv | 22 ++
 rtl/adder_pipe_sched_rr_arbiter.sv | 37 +++
 rtl/adder_pipe_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared constants, scheduler state encoding and the tag carried alongside
// each operation through the adder pipe.
package adder_pipe_pkg;

   localparam int APS_DATA_WIDTH = 64;
   localparam int APS_NREQ       = 4;
   localparam int APS_ID_W       = 2;
   localparam int APS_PIPE_LAT   = 4;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } sched_state_e;

   // One slot of the tag shift register: marks an issued op and its owner.
   typedef struct packed {
      logic                valid;
      logic [APS_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/adder_pipe_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping modulo NREQ. Pure combinational; the caller owns the pointer.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] idx,
   output logic            any
);

   logic [ID_W:0] pos;

   // Scan from the farthest offset down so the nearest request to ptr wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      pos = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         pos = {1'b0, ptr} + (ID_W + 1)'(k);
         if (pos >= (ID_W + 1)'(NREQ)) begin
            pos = pos - (ID_W + 1)'(NREQ);
         end
         if (req[pos[ID_W-1:0]]) begin
            idx = pos[ID_W-1:0];
            any = 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign grant[gi] = any && (idx == ID_W'(gi));
   end

endmodule

// File: rtl/adder_pipe_sched.sv
// Shares one fixed-latency adder pipe among NREQ requesters. One op may be
// issued per cycle; a tag shift register that mirrors the pipe latency routes
// each result back to its owner. A drain mode stops intake and waits for all
// in-flight ops to come back before reporting quiescence.
module adder_pipe_sched
   import adder_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = APS_DATA_WIDTH,
   parameter int NREQ       = APS_NREQ,
   parameter int ID_W       = APS_ID_W,
   parameter int PIPE_LAT   = APS_PIPE_LAT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*DATA_WIDTH-1:0] req_a,
   input  logic [NREQ*DATA_WIDTH-1:0] req_b,
   output logic                       pipe_en,
   output logic [DATA_WIDTH-1:0]      pipe_a,
   output logic [DATA_WIDTH-1:0]      pipe_b,
   input  logic [DATA_WIDTH:0]        pipe_res,
   input  logic                       pipe_oen,
   output logic                       rsp_valid,
   output logic [ID_W-1:0]            rsp_id,
   output logic [DATA_WIDTH:0]        rsp_data,
   input  logic                       drain_req,
   output logic                       drain_done,
   output logic                       err_tag
);

   localparam int INF_W = $clog2(PIPE_LAT + 2) + 1;

   sched_state_e     state_reg;
   sched_state_e     state_next;
   logic [ID_W-1:0]  ptr_reg;
   logic [ID_W-1:0]  issue_id_reg;
   logic [INF_W-1:0] inflight_reg;
   tag_t             tag_reg [PIPE_LAT];
   tag_t             tail;

   logic [NREQ-1:0]  arb_grant;
   logic [ID_W-1:0]  arb_idx;
   logic             arb_any;
   logic             accept_en;
   logic             take;

   rr_arbiter #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr_reg),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign take      = accept_en & arb_any;
   assign req_ready = accept_en ? arb_grant : '0;
   assign tail      = tag_reg[PIPE_LAT-1];

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state: a grant in the cycle drain_req rises is still honoured.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (drain_req) state_next = DRAIN;
         DRAIN:   if (inflight_reg == '0) state_next = DRAINED;
         DRAINED: if (!drain_req) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // State-decoded outputs; intake is also blocked while reset is asserted.
   always_comb begin
      accept_en  = 1'b0;
      drain_done = 1'b0;
      case (state_reg)
         RUN:     accept_en = rst_n;
         DRAINED: drain_done = 1'b1;
         default: ;
      endcase
   end

   // Issue register: capture the granted operands and advance the RR pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe_en      <= 1'b0;
         pipe_a       <= '0;
         pipe_b       <= '0;
         issue_id_reg <= '0;
         ptr_reg      <= '0;
      end else begin
         pipe_en <= take;
         if (take) begin
            pipe_a       <= req_a[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
            pipe_b       <= req_b[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
            issue_id_reg <= arb_idx;
            ptr_reg      <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
         end
      end
   end

   // Tag shift register: entries enter alongside pipe_en so the tail lines up with pipe_oen.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            tag_reg[i] <= '0;
         end
      end else begin
         tag_reg[0].valid <= pipe_en;
         tag_reg[0].id    <= issue_id_reg;
         for (int i = 1; i < PIPE_LAT; i++) begin
            tag_reg[i] <= tag_reg[i-1];
         end
      end
   end

   // Response register and sticky tag/result mismatch flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         err_tag   <= 1'b0;
      end else begin
         rsp_valid <= pipe_oen;
         if (pipe_oen) begin
            rsp_id   <= tail.id;
            rsp_data <= pipe_res;
         end
         if (pipe_oen ^ tail.valid) begin
            err_tag <= 1'b1;
         end
      end
   end

   // In-flight count: up on accept, down on response; a spurious response never underflows it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight_reg <= '0;
      end else if (take && !rsp_valid) begin
         inflight_reg <= inflight_reg + 1'b1;
      end else if (!take && rsp_valid && (inflight_reg != '0)) begin
         inflight_reg <= inflight_reg - 1'b1;
      end
   end

endmodule
